// File: rtl/misc_iter.sv
// misc_iter: sequential misc unit beside the main ALU.
// Single-cycle mul10 / xor, plus an iterative restoring divider shared by
// div10, unsigned divide and unsigned remainder. One operation in flight,
// valid/ready handshake on both the request and the result side.
module misc_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] dvd;     // dividend shifts out the top, quotient shifts in the bottom
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;
  logic             op_rem;

  logic             accept, is_div, last, ge;
  logic [WIDTH:0]   r_sh, r_sub, r_nx;
  logic [WIDTH-1:0] q_nx, short_res;

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign is_div    = (control == 3'd1) || (control == 3'd3) || (control == 3'd4);
  assign last      = (cnt == CW'(1));

  // One restoring step. A zero divisor makes every step "fit", which yields
  // the all-ones quotient and leaves the dividend as remainder.
  always_comb begin
    r_sh  = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    r_sub = r_sh - {1'b0, dvs};
    ge    = rem[WIDTH] || (r_sh >= {1'b0, dvs});
    r_nx  = ge ? r_sub : r_sh;
    q_nx  = {dvd[WIDTH-2:0], ge};
  end

  // Single-cycle ops: mul10 by shift-add (wraps), everything else is xor.
  always_comb begin
    short_res = a ^ b;
    if (control == 3'd0) short_res = (a << 3) + (a << 1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = is_div ? RUN : DONE;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one divider step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      op_rem <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (is_div) begin
            dvd    <= a;
            dvs    <= (control == 3'd1) ? TEN : b;
            rem    <= '0;
            cnt    <= CW'(WIDTH);
            op_rem <= (control == 3'd4);
          end else begin
            result <= short_res;
          end
        end
        RUN: begin
          dvd <= q_nx;
          rem <= r_nx;
          cnt <= cnt - CW'(1);
          if (last) result <= op_rem ? r_nx[WIDTH-1:0] : q_nx;
        end
        default: ;
      endcase
    end
  end
endmodule
